// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_DONE,
        ST_FAULT
    } fetch_state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter: async reset, synchronous jump load, increment with wrap.
module pc_counter
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        // NOTE: default first so every path assigns pc_d; otherwise a latch is inferred.
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request/ack memory read, IR load strobe,
// fetch-complete pulse and a sticky fault on memory timeout.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir_d,
    output logic              ir_read,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done,
    output logic              fault
);

    // Counter only needs to reach TIMEOUT-1; the next missed ack is the fault.
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [DATA_W-1:0] ir_d_q, ir_d_d;
    logic              ir_read_q, ir_read_d;
    logic              busy_q, busy_d;
    logic              fetch_done_q, fetch_done_d;
    logic              fault_q, fault_d;
    logic              pc_load;
    logic              pc_inc;

    pc_counter #(
        .ADDR_W(ADDR_W)
    ) u_pc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_addr(jump_addr),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        mem_addr_d = mem_addr_q;
        ir_d_d     = ir_d_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A jump drops a simultaneous fetch request.
                if (jump_en) begin
                    pc_load = 1'b1;
                end else if (fetch_req) begin
                    state_d    = ST_REQ;
                    mem_addr_d = pc;
                    to_cnt_d   = '0;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    ir_d_d  = mem_rdata;
                    state_d = ST_LOAD;
                end else if (to_cnt_q == CNT_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                pc_inc  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        // Strobes trail their state by one edge so fetch_done follows the IR latch.
        mem_rd_d     = (state_d == ST_REQ);
        ir_read_d    = (state_q == ST_LOAD);
        fetch_done_d = (state_q == ST_DONE);
        busy_d       = (state_d != ST_IDLE) || (state_q == ST_DONE);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            to_cnt_q     <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            ir_d_q       <= '0;
            ir_read_q    <= 1'b0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            ir_d_q       <= ir_d_d;
            ir_read_q    <= ir_read_d;
            busy_q       <= busy_d;
            fetch_done_q <= fetch_done_d;
            fault_q      <= fault_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign ir_d       = ir_d_q;
    assign ir_read    = ir_read_q;
    assign busy       = busy_q;
    assign fetch_done = fetch_done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written timeout and reset sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_addr = 8'h00;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] ir_d;
    logic        ir_read;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_done;
    logic        fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W (8),
        .DATA_W (16),
        .TIMEOUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir_d      (ir_d),
        .ir_read   (ir_read),
        .pc        (pc),
        .busy      (busy),
        .fetch_done(fetch_done),
        .fault     (fault)
    );

    typedef struct {
        logic        fetch_req;
        logic        jump_en;
        logic [7:0]  jump_addr;
        logic        mem_ack;
        logic [15:0] mem_rdata;
        logic [7:0]  e_mem_addr;
        logic        e_mem_rd;
        logic [15:0] e_ir_d;
        logic        e_ir_read;
        logic [7:0]  e_pc;
        logic        e_busy;
        logic        e_fetch_done;
        logic        e_fault;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 8'h00;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
    endtask

    task automatic check_status(input string tag, input logic [7:0] e_addr, input logic e_rd,
                                input logic [7:0] e_pc, input logic e_busy, input logic e_fault);
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
        check({tag, ".mem_rd"},   32'(mem_rd),   32'(e_rd));
        check({tag, ".pc"},       32'(pc),       32'(e_pc));
        check({tag, ".busy"},     32'(busy),     32'(e_busy));
        check({tag, ".fault"},    32'(fault),    32'(e_fault));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          fr    je    ja     ack   rdata      | addr   rd    ir_d       irr   pc     busy  fd    flt
        // basic fetch, ack two cycles after mem_rd; stray acks in LOAD, DONE and IDLE
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA5C3, 8'h00, 1'b0, 16'hA5C3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 8'h00, 1'b0, 16'hA5C3, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFF, 8'h00, 1'b0, 16'hA5C3, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFF, 8'h00, 1'b0, 16'hA5C3, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        // jump to FF, fastest fetch, pc wraps to 0
        vecs[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000, 8'h00, 1'b0, 16'hA5C3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'hFF, 1'b1, 16'hA5C3, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h1357, 8'hFF, 1'b0, 16'h1357, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'hFF, 1'b0, 16'h1357, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'hFF, 1'b0, 16'h1357, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'hFF, 1'b0, 16'h1357, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        // jump and fetch together: jump wins, no request
        vecs[12] = '{1'b1, 1'b1, 8'h3C, 1'b0, 16'h0000, 8'hFF, 1'b0, 16'h1357, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'hFF, 1'b0, 16'h1357, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
        // fetch with ack on the final timeout cycle; jump ignored while in REQ
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h1357, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'h77, 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h1357, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h1357, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h3C, 1'b1, 16'h1357, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hBEEF, 8'h3C, 1'b0, 16'hBEEF, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h3C, 1'b0, 16'hBEEF, 1'b1, 8'h3D, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h3C, 1'b0, 16'hBEEF, 1'b0, 8'h3D, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 8'h3C, 1'b0, 16'hBEEF, 1'b0, 8'h3D, 1'b0, 1'b0, 1'b0};

        // reset and its values
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_status("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check("reset.ir_d",       32'(ir_d),       32'h0);
        check("reset.ir_read",    32'(ir_read),    32'h0);
        check("reset.fetch_done", 32'(fetch_done), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            fetch_req = vecs[i].fetch_req;
            jump_en   = vecs[i].jump_en;
            jump_addr = vecs[i].jump_addr;
            mem_ack   = vecs[i].mem_ack;
            mem_rdata = vecs[i].mem_rdata;
            step();
            check($sformatf("v%0d.mem_addr", i),   32'(mem_addr),   32'(vecs[i].e_mem_addr));
            check($sformatf("v%0d.mem_rd", i),     32'(mem_rd),     32'(vecs[i].e_mem_rd));
            check($sformatf("v%0d.ir_d", i),       32'(ir_d),       32'(vecs[i].e_ir_d));
            check($sformatf("v%0d.ir_read", i),    32'(ir_read),    32'(vecs[i].e_ir_read));
            check($sformatf("v%0d.pc", i),         32'(pc),         32'(vecs[i].e_pc));
            check($sformatf("v%0d.busy", i),       32'(busy),       32'(vecs[i].e_busy));
            check($sformatf("v%0d.fetch_done", i), 32'(fetch_done), 32'(vecs[i].e_fetch_done));
            check($sformatf("v%0d.fault", i),      32'(fault),      32'(vecs[i].e_fault));
        end
        idle_inputs();

        // timeout: no ack for four REQ cycles, pc = 3D
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check_status("to.req", 8'h3D, 1'b1, 8'h3D, 1'b1, 1'b0);
        step();
        step();
        step();
        check_status("to.edge3", 8'h3D, 1'b1, 8'h3D, 1'b1, 1'b0);
        step();
        check_status("to.fault", 8'h3D, 1'b0, 8'h3D, 1'b1, 1'b1);
        // fault is sticky; requests, jumps and acks are all ignored
        fetch_req = 1'b1;
        jump_en   = 1'b1;
        jump_addr = 8'h55;
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            check_status($sformatf("to.hold%0d", i), 8'h3D, 1'b0, 8'h3D, 1'b1, 1'b1);
            check($sformatf("to.hold%0d.ir_d", i), 32'(ir_d), 32'hBEEF);
        end
        idle_inputs();
        rst = 1'b1;
        #2;
        check_status("to.rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check("to.rst.ir_d", 32'(ir_d), 32'h0);
        rst = 1'b0;
        step();

        // reset between edges while in REQ
        jump_en   = 1'b1;
        jump_addr = 8'h42;
        step();
        jump_en   = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check_status("mid.req", 8'h42, 1'b1, 8'h42, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        #2;
        check_status("mid.rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check_status("mid.refetch", 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = 16'h0F0F;
        step();
        idle_inputs();
        check("mid.ir_d", 32'(ir_d), 32'h0F0F);
        step();
        check("mid.ir_read", 32'(ir_read), 32'h1);
        step();
        check("mid.fetch_done", 32'(fetch_done), 32'h1);
        step();
        check_status("mid.end", 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction register. It holds the program counter and runs a request/acknowledge read against instruction memory. It delivers each fetched word to the IR data input with a one-cycle load strobe, then signals the control unit that the IR holds a fresh instruction. It also supports absolute jumps and flags memory that fails to respond.

## Interface
- ADDR_W, default 8: program-counter and memory-address width.
- DATA_W, default 16: instruction width; matches the IR data input.
- TIMEOUT, default 16: maximum cycles in REQ without `mem_ack` before a fault is raised; must be ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- fetch_req  in  1  control unit requests the next instruction; sampled only in IDLE.
- jump_en  in  1  load the PC from `jump_addr`; sampled only in IDLE.
- jump_addr  in  ADDR_W  jump target.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_rd  out  1  memory read request; held high until acknowledged.
- mem_rdata  in  DATA_W  memory read data; valid while `mem_ack` is high.
- mem_ack  in  1  memory acknowledge, one cycle or longer.
- ir_d  out  DATA_W  instruction word, wired to the IR `D` input.
- ir_read  out  1  one-cycle IR load strobe, wired to the IR `read` input.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in every state except IDLE.
- fetch_done  out  1  one-cycle pulse: the IR now holds the new instruction.
- fault  out  1  sticky memory-timeout flag.

## Operation
- **FSM states:** IDLE, REQ, LOAD, DONE, FAULT. All outputs are registered.
- **IDLE**
  - `jump_en` = 1: `pc` ← `jump_addr`; stay in IDLE.
  - `jump_en` = 1 and `fetch_req` = 1 in the same cycle: the jump wins and `fetch_req` is dropped. The control unit must re-request.
  - `fetch_req` = 1 alone: go to REQ, with `mem_addr` ← `pc` and `mem_rd` ← 1.
- **REQ**
  - `mem_rd` and `mem_addr` are held stable.
  - `mem_ack` = 1: capture `mem_rdata` into `ir_d`, drop `mem_rd`, go to LOAD.
  - Timeout counter increments each REQ cycle without ack. When the count reaches TIMEOUT, go to FAULT.
  - If ack and timeout coincide, the ack wins.
- **LOAD**
  - `ir_read` = 1 for exactly this cycle.
  - `pc` ← `pc` + 1, modulo 2^ADDR_W; all-ones wraps to 0.
  - Go to DONE.
- **DONE:** `fetch_done` = 1 for one cycle, then go to IDLE.
- **FAULT:** `fault` = 1 and `mem_rd` = 0; `pc` is unchanged. Only `rst` exits this state.
- **Ignored inputs:**
  - `mem_ack` outside REQ.
  - `fetch_req` and `jump_en` outside IDLE.
- `ir_d` holds its last captured value until the next capture.

## Timing
- **Reset values:** state IDLE; `pc`, `mem_addr`, `ir_d` all zero; `mem_rd`, `ir_read`, `busy`, `fetch_done`, `fault` all 0.
- **Reset mid-operation:** all outputs go to their reset values immediately, without waiting for a clock edge. Any outstanding memory request is abandoned.
- **Cycle sequence:** `fetch_req` sampled at edge 0; `mem_rd` high after edge 0.
  - With `mem_ack` sampled at edge k: `ir_read` high after edge k+1, IR updates at edge k+2.
  - `fetch_done` high after edge k+2.
  - `busy` falls after edge k+3.
- **Fastest fetch:** ack at edge 1 gives 4 cycles from request to the return to IDLE.
- **Ordering guarantee:** `fetch_done` is asserted only after the IR has latched, so the control unit may issue `writeA`/`writeB` in the `fetch_done` cycle.
- **Jump latency:** `pc` takes `jump_addr` one edge after `jump_en` is sampled.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum: IDLE, REQ, LOAD, DONE, FAULT.
  - Default ADDR_W, DATA_W and TIMEOUT constants.
- One sub-module, `pc_counter`: ADDR_W-bit register with async reset, synchronous load (jump) and increment-with-wrap.
- The FSM, timeout counter and data capture stay in `fetch_unit`.

## Test plan
- **Basic fetch:** reset, `fetch_req`, memory returns 16'hA5C3 with ack 2 cycles after `mem_rd` → `mem_addr` = 0, `ir_read` for 1 cycle with `ir_d` = A5C3, `fetch_done` one cycle later, `pc` = 1.
- **Jump, then jump+fetch:** `jump_en` with `jump_addr` = 8'hFF, then fetch → `mem_addr` = FF and `pc` wraps to 0. Separately, `jump_en` and `fetch_req` in the same cycle → PC loaded, no `mem_rd`, `busy` stays 0.
- **Timeout:** TIMEOUT = 4, no ack → FAULT entered after 4 REQ cycles, `mem_rd` = 0, `fault` stays 1 while further `fetch_req` is applied; `rst` clears it.
- **Ack/timeout race:** ack on the final timeout cycle → normal LOAD, `fault` = 0.
- **Reset mid-op:** `rst` asserted between clock edges while in REQ → `mem_rd`, `busy` and `pc` go to 0 immediately; the next fetch reads address 0.
- **Stray ack:** `mem_ack` pulses while in IDLE and DONE → no state or `ir_d` change.
